bomb_timer_ctrl: RTL and testbench
==================================

// Module: bomb_timer_ctrl
// PURPOSE
//  Game countdown controller. Sequences the 1 ms LFSR tick generator and turns its
//  tick into a BCD seconds countdown with start, pause, penalty and defuse control.
//  Sits between the game FSM (inputs and puzzles) and the 7-segment display and
//  explosion logic.
//  Gates the tick generator through its active-low reset so ticks are produced only while running.
// PARAMETERS
//  START_SECS    99    initial and reload countdown value, 0..99
//  MS_PER_SEC    1000  tick pulses per second; benches override to 4
//  PENALTY_SECS  10    seconds removed per penalty pulse, 1..99
// PORTS
//  clk             in   1  system clock
//  rst             in   1  asynchronous, active-low reset
//  uno_ms_timeout  in   1  1-cycle 1 ms tick from the tick generator
//  tick_rst        out  1  active-low sync reset to the tick generator; 1 only in RUN
//  start           in   1  1-cycle pulse: arm/resume/reload
//  pause           in   1  1-cycle pulse: RUN->HALT
//  penalty         in   1  1-cycle pulse: subtract PENALTY_SECS
//  defuse          in   1  1-cycle pulse: stop countdown, win
//  secs_tens       out  4  BCD tens of remaining seconds
//  secs_ones       out  4  BCD ones of remaining seconds
//  state           out  3  IDLE=0 RUN=1 HALT=2 EXPLODED=3 DEFUSED=4
//  exploded        out  1  high while state==EXPLODED
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, secs=START_SECS, ms_cnt=0, tick_rst=0, exploded=0.
//  - All outputs are registered; tick_rst=1 exactly when state==RUN (same-cycle update as state).
//  - IDLE: start -> RUN. Other inputs are ignored.
//  - RUN: uno_ms_timeout increments ms_cnt. When ms_cnt==MS_PER_SEC-1 and a tick arrives:
//    ms_cnt<=0 and secs decrements in BCD (x0 -> (x-1)9).
//    If secs==00 at that wrap, go to EXPLODED instead.
//    pause -> HALT. ms_cnt and secs are held; the partial second is kept.
//  - HALT: start -> RUN. Ticks are ignored, but the generator is held in reset anyway.
//  - penalty (RUN or HALT): secs <= max(secs-PENALTY_SECS,0). If the result is 0, go to EXPLODED
//    next cycle. ms_cnt is unchanged. Penalty is ignored in IDLE and terminal states.
//  - defuse (RUN or HALT) -> DEFUSED. secs is frozen at its current value.
//  - Priority for same-cycle events: defuse > penalty > pause > tick.
//    A tick arriving with any higher-priority event is dropped.
//  - EXPLODED/DEFUSED: terminal. secs is held (00 when EXPLODED).
//    start reloads secs=START_SECS, ms_cnt=0 and goes to RUN.
//  - start while in RUN is ignored (no reload).
//  - Width rules: ms_cnt width = clog2(MS_PER_SEC). secs is kept as two BCD digits.
//    Penalty subtraction is done in binary, 0..99, then converted to BCD.
//  - Mid-operation reset aborts immediately to the reset values. The generator restarts
//    its 50k-cycle period on the next RUN, so the first second may be longer by up to 1 ms.
// STRUCTURE
//  - Shared package/header: state encodings (IDLE..DEFUSED), BCD digit width, default
//    START_SECS/PENALTY_SECS.
//  - Sub-module bcd_sub_sat: 2-digit BCD minus binary 0..99, saturating at 00, with a zero flag.
//    It serves both the decrement-by-1 and penalty paths.
//  - Top-level: state FSM, ms_cnt, secs registers, tick_rst register.
// TESTING (MS_PER_SEC=4, START_SECS=3, PENALTY_SECS=2)
//  1. Reset, then start, then 16 ticks -> secs 03,02,01,00 every 4 ticks, EXPLODED on the 16th
//     tick, exploded=1, tick_rst=0.
//  2. start, 6 ticks, pause, 5 ticks, start, 2 ticks -> secs=01 after the final tick
//     (halted ticks ignored, ms_cnt kept).
//  3. start, penalty -> secs=01. A second penalty -> secs=00 and EXPLODED next cycle.
//     secs never wraps to 99.
//  4. start, 5 ticks, then defuse and penalty and tick in the same cycle -> DEFUSED,
//     secs=02 frozen, tick_rst=0.
//  5. In DEFUSED, start -> RUN, secs=03, ms_cnt=0. Assert rst=0 mid-count -> IDLE and
//     secs=03 asynchronously, without waiting for a clock edge.
//  6. IDLE: penalty, pause, defuse and ticks all applied -> no change. tick_rst stays 0 throughout.

Source files
------------

// File: rtl/bomb_timer_ctrl_pkg.sv
// Shared definitions for the bomb countdown controller: state encodings, BCD digit
// width and default timing parameters.
package bomb_timer_ctrl_pkg;

  localparam int unsigned BcdW           = 4;
  localparam int unsigned DefStartSecs   = 99;
  localparam int unsigned DefPenaltySecs = 10;
  localparam int unsigned DefMsPerSec    = 1000;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StRun      = 3'd1,
    StHalt     = 3'd2,
    StExploded = 3'd3,
    StDefused  = 3'd4
  } state_e;

endpackage

// File: rtl/bomb_timer_ctrl_bcd_sub_sat.sv
// Two-digit BCD minus a binary amount (0..99), saturating at 00, with a zero flag.
module bomb_timer_ctrl_bcd_sub_sat
  import bomb_timer_ctrl_pkg::*;
(
  input  logic [BcdW-1:0] tens_i,
  input  logic [BcdW-1:0] ones_i,
  input  logic [6:0]      sub_i,
  output logic [BcdW-1:0] tens_o,
  output logic [BcdW-1:0] ones_o,
  output logic            zero_o
);

  logic [7:0] minuend;
  logic [7:0] subtrahend;
  logic [7:0] diff;

  always_comb begin
    minuend    = 8'(tens_i) * 8'd10 + 8'(ones_i);
    subtrahend = {1'b0, sub_i};
    diff       = (minuend > subtrahend) ? (minuend - subtrahend) : 8'd0;
    tens_o     = 4'(diff / 8'd10);
    ones_o     = 4'(diff % 8'd10);
    zero_o     = (diff == 8'd0);
  end

endmodule

// File: rtl/bomb_timer_ctrl.sv
// Game countdown controller: gates the 1 ms tick generator and turns its ticks into a
// BCD seconds countdown with start, pause, penalty and defuse control.
module bomb_timer_ctrl
  import bomb_timer_ctrl_pkg::*;
#(
  parameter int unsigned START_SECS   = DefStartSecs,
  parameter int unsigned MS_PER_SEC   = DefMsPerSec,
  parameter int unsigned PENALTY_SECS = DefPenaltySecs
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            uno_ms_timeout,
  output logic            tick_rst,
  input  logic            start,
  input  logic            pause,
  input  logic            penalty,
  input  logic            defuse,
  output logic [BcdW-1:0] secs_tens,
  output logic [BcdW-1:0] secs_ones,
  output logic [2:0]      state,
  output logic            exploded
);

  localparam int unsigned MsW = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;
  localparam logic [MsW-1:0]  MsLast    = MsW'(MS_PER_SEC - 1);
  localparam logic [BcdW-1:0] StartTens = BcdW'(START_SECS / 10);
  localparam logic [BcdW-1:0] StartOnes = BcdW'(START_SECS % 10);

  state_e          state_q, state_d;
  logic [MsW-1:0]  ms_cnt_q, ms_cnt_d;
  logic [BcdW-1:0] tens_q, tens_d;
  logic [BcdW-1:0] ones_q, ones_d;
  logic            tick_rst_q, exploded_q;

  logic [6:0]      sub_amt;
  logic [BcdW-1:0] sub_tens, sub_ones;
  logic            sub_zero;
  logic            secs_zero;
  logic            sec_wrap;

  // One subtractor serves both the per-second decrement and the penalty.
  assign sub_amt = penalty ? 7'(PENALTY_SECS) : 7'd1;

  bomb_timer_ctrl_bcd_sub_sat u_bcd_sub_sat (
    .tens_i (tens_q),
    .ones_i (ones_q),
    .sub_i  (sub_amt),
    .tens_o (sub_tens),
    .ones_o (sub_ones),
    .zero_o (sub_zero)
  );

  assign secs_zero = (tens_q == '0) && (ones_q == '0);
  assign sec_wrap  = uno_ms_timeout && (ms_cnt_q == MsLast);

  always_comb begin
    state_d  = state_q;
    ms_cnt_d = ms_cnt_q;
    tens_d   = tens_q;
    ones_d   = ones_q;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun, StHalt: begin
        // Priority: defuse > penalty > pause/start > tick.
        if (defuse) begin
          state_d = StDefused;
        end else if (penalty) begin
          tens_d = sub_tens;
          ones_d = sub_ones;
          if (sub_zero) state_d = StExploded;
        end else if (state_q == StRun) begin
          if (pause) begin
            state_d = StHalt;
          end else if (uno_ms_timeout) begin
            if (sec_wrap) begin
              ms_cnt_d = '0;
              if (secs_zero) begin
                state_d = StExploded;
              end else begin
                tens_d = sub_tens;
                ones_d = sub_ones;
              end
            end else begin
              ms_cnt_d = MsW'(ms_cnt_q + 1'b1);
            end
          end
        end else if (start) begin
          state_d = StRun;
        end
      end
      StExploded, StDefused: begin
        if (start) begin
          state_d  = StRun;
          ms_cnt_d = '0;
          tens_d   = StartTens;
          ones_d   = StartOnes;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      ms_cnt_q   <= '0;
      tens_q     <= StartTens;
      ones_q     <= StartOnes;
      tick_rst_q <= 1'b0;
      exploded_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ms_cnt_q   <= ms_cnt_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      tick_rst_q <= (state_d == StRun);
      exploded_q <= (state_d == StExploded);
    end
  end

  assign state     = state_q;
  assign secs_tens = tens_q;
  assign secs_ones = ones_q;
  assign tick_rst  = tick_rst_q;
  assign exploded  = exploded_q;

endmodule

// File: tb/tb_bomb_timer_ctrl.sv
// Bench for bomb_timer_ctrl: directed scenarios plus random traffic, checked every
// cycle against an arithmetic model of the countdown rules.
module tb_bomb_timer_ctrl;

  localparam int unsigned StartSecs = 3;
  localparam int unsigned MsPerSec  = 4;
  localparam int unsigned PenSecs   = 2;

  logic       clk, rst;
  logic       uno, tick_rst, start, pause, penalty, defuse;
  logic [3:0] tens, ones;
  logic [2:0] st;
  logic       expl;

  int n_total, n_pass;

  // Pinned literal expectations, driven by the stimulus, checked by the compare process.
  logic  pin_on;
  string pin_tag;
  int    pin_state, pin_secs, pin_tr, pin_ex;

  // Model: 0 idle, 1 run, 2 halt, 3 exploded, 4 defused; secs held as a plain integer.
  int m_state, m_secs, m_ms;

  bomb_timer_ctrl #(
    .START_SECS   (StartSecs),
    .MS_PER_SEC   (MsPerSec),
    .PENALTY_SECS (PenSecs)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .uno_ms_timeout (uno),
    .tick_rst       (tick_rst),
    .start          (start),
    .pause          (pause),
    .penalty        (penalty),
    .defuse         (defuse),
    .secs_tens      (tens),
    .secs_ones      (ones),
    .state          (st),
    .exploded       (expl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin : model
    int ns, nsec, nms;
    if (!rst) begin
      m_state <= 0;
      m_secs  <= StartSecs;
      m_ms    <= 0;
    end else begin
      ns   = m_state;
      nsec = m_secs;
      nms  = m_ms;
      if (m_state == 0) begin
        if (start) ns = 1;
      end else if (m_state == 1 || m_state == 2) begin
        if (defuse) begin
          ns = 4;
        end else if (penalty) begin
          nsec = (m_secs > PenSecs) ? m_secs - PenSecs : 0;
          if (nsec == 0) ns = 3;
        end else if (m_state == 1) begin
          if (pause) begin
            ns = 2;
          end else if (uno) begin
            if (m_ms == MsPerSec - 1) begin
              nms = 0;
              if (m_secs == 0) ns = 3;
              else nsec = m_secs - 1;
            end else begin
              nms = m_ms + 1;
            end
          end
        end else if (start) begin
          ns = 1;
        end
      end else if (start) begin
        ns   = 1;
        nsec = StartSecs;
        nms  = 0;
      end
      m_state <= ns;
      m_secs  <= nsec;
      m_ms    <= nms;
    end
  end

  always @(negedge clk) begin : compare
    chk("state", int'(st), m_state);
    chk("secs_tens", int'(tens), m_secs / 10);
    chk("secs_ones", int'(ones), m_secs % 10);
    chk("tick_rst", int'(tick_rst), (m_state == 1) ? 1 : 0);
    chk("exploded", int'(expl), (m_state == 3) ? 1 : 0);
    if (pin_on) begin
      chk({pin_tag, "_state"}, int'(st), pin_state);
      chk({pin_tag, "_secs"}, int'(tens) * 10 + int'(ones), pin_secs);
      chk({pin_tag, "_tick_rst"}, int'(tick_rst), pin_tr);
      chk({pin_tag, "_exploded"}, int'(expl), pin_ex);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic step(input bit s, input bit pa, input bit pe, input bit d, input bit t);
    start   = s;
    pause   = pa;
    penalty = pe;
    defuse  = d;
    uno     = t;
    @(posedge clk);
    #1;
    start   = 1'b0;
    pause   = 1'b0;
    penalty = 1'b0;
    defuse  = 1'b0;
    uno     = 1'b0;
  endtask

  task automatic pin(input string tag, input int s, input int secs, input int tr, input int ex);
    pin_tag   = tag;
    pin_state = s;
    pin_secs  = secs;
    pin_tr    = tr;
    pin_ex    = ex;
    pin_on    = 1'b1;
    @(negedge clk);
    #1;
    pin_on    = 1'b0;
  endtask

  initial begin
    int r;
    n_total = 0;
    n_pass  = 0;
    pin_on  = 1'b0;
    pin_tag = "none";
    rst = 1'b0;
    uno = 1'b0; start = 1'b0; pause = 1'b0; penalty = 1'b0; defuse = 1'b0;

    @(negedge clk);
    pin("reset", 0, 3, 0, 0);
    rst = 1'b1;

    // 1: full countdown to explosion
    step(1, 0, 0, 0, 0);
    pin("s1_run", 1, 3, 1, 0);
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 0, 0, 1);
      if (i == 4)  pin("s1_t4", 1, 2, 1, 0);
      if (i == 8)  pin("s1_t8", 1, 1, 1, 0);
      if (i == 12) pin("s1_t12", 1, 0, 1, 0);
    end
    pin("s1_boom", 3, 0, 0, 1);

    // 2: pause keeps the partial second
    step(1, 0, 0, 0, 0);
    repeat (6) step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    pin("s2_halt", 2, 2, 0, 0);
    repeat (5) step(0, 0, 0, 0, 1);
    pin("s2_held", 2, 2, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 1);
    pin("s2_resume", 1, 1, 1, 0);

    // 3: penalties saturate at 00 and explode
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    pin("s3_pen1", 1, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    pin("s3_pen2", 3, 0, 0, 1);

    // 4: defuse wins over simultaneous penalty and tick
    step(1, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 1);
    step(0, 0, 1, 1, 1);
    pin("s4_defused", 4, 2, 0, 0);

    // 5: reload from DEFUSED, then asynchronous reset mid-count
    step(1, 0, 0, 0, 0);
    pin("s5_reload", 1, 3, 1, 0);
    repeat (3) step(0, 0, 0, 0, 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    pin("s5_async", 0, 3, 0, 0);
    rst = 1'b1;

    // 6: IDLE ignores everything but start
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0, 1);
    pin("s6_idle", 0, 3, 0, 0);

    // Random traffic: at most one control pulse per cycle, plus the rare full pile-up.
    for (int c = 0; c < 3000; c++) begin
      r = int'($urandom_range(0, 99));
      start   = (r < 4);
      pause   = (r >= 4 && r < 8);
      penalty = (r >= 8 && r < 11) || (r == 12);
      defuse  = (r == 11) || (r == 12);
      uno     = ($urandom_range(0, 1) == 1) || (r == 12);
      @(posedge clk);
      #1;
    end
    start = 1'b0; pause = 1'b0; penalty = 1'b0; defuse = 1'b0; uno = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
